// File: rtl/snn_syn_pkg.sv
// Shared types and helpers for the synapse fan-out stage: scan states,
// derived group geometry and lane slicing of the packed weight bus.
package snn_syn_pkg;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN      = 1'b1
  } scan_state_t;

  function automatic int group_count(input int neurons, input int lanes);
    return neurons / lanes;
  endfunction

  function automatic int group_id_width(input int neurons, input int lanes);
    int w;
    w = $clog2(neurons) - $clog2(lanes);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/syn_spike_fifo.sv
// Synchronous show-ahead FIFO for incoming axon ids, with registered
// full/empty flags and an occupancy count.
module syn_spike_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W:0]   count_next;

  assign do_pop     = pop && !empty;
  // A full FIFO still takes a push when the same cycle frees an entry.
  assign do_push    = push && (!full || do_pop);
  assign count_next = count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
  assign rd_data    = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PTR_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/synapse_array_mc.sv
// Synapse fan-out: buffers axon spikes, scans each axon's weight row one
// lane group per cycle from banked RAM and emits nonzero groups downstream.
module synapse_array_mc
  import snn_syn_pkg::*;
#(
  parameter int NUM_AXONS       = 256,
  parameter int NUM_NEURONS     = 256,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int NUM_LANES       = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int AXON_ID_WIDTH   = $clog2(NUM_AXONS),
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
  parameter int GROUP_ID_WIDTH  = group_id_width(NUM_NEURONS, NUM_LANES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              s_spike_valid,
  output logic                              s_spike_ready,
  input  logic [AXON_ID_WIDTH-1:0]          s_spike_axon_id,
  output logic                              m_syn_valid,
  input  logic                              m_syn_ready,
  output logic [GROUP_ID_WIDTH-1:0]         m_syn_group_id,
  output logic [NUM_LANES*WEIGHT_WIDTH-1:0] m_syn_weights,
  output logic [NUM_LANES-1:0]              m_syn_mask,
  output logic                              m_syn_last,
  input  logic                              cfg_we,
  input  logic [AXON_ID_WIDTH-1:0]          cfg_axon,
  input  logic [NEURON_ID_WIDTH-1:0]        cfg_neuron,
  input  logic [WEIGHT_WIDTH-1:0]           cfg_weight,
  output logic                              busy,
  output logic [31:0]                       stat_groups
);

  localparam int GROUPS     = group_count(NUM_NEURONS, NUM_LANES);
  localparam int BANK_DEPTH = NUM_AXONS * GROUPS;
  localparam int ADDR_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [GROUP_ID_WIDTH-1:0] LAST_G = GROUP_ID_WIDTH'(GROUPS - 1);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [AXON_ID_WIDTH-1:0] axon,
                                                input int grp);
    return ADDR_W'(int'(axon) * GROUPS + grp);
  endfunction

  scan_state_t                       state;
  logic [AXON_ID_WIDTH-1:0]          axon_q;
  logic [GROUP_ID_WIDTH-1:0]         g;
  logic                              push;
  logic                              pop;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [AXON_ID_WIDTH-1:0]          fifo_axon;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;
  logic                              advance;
  logic                              g_last;
  logic                              rd_en;
  logic [ADDR_W-1:0]                 rd_addr;
  logic [ADDR_W-1:0]                 cfg_addr;
  int                                cfg_lane;
  logic [NUM_LANES*WEIGHT_WIDTH-1:0] rd_data;
  logic [NUM_LANES-1:0]              rd_mask;

  syn_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXON_ID_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (s_spike_axon_id),
    .rd_data (fifo_axon),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_spike_ready = !fifo_full;
  assign push          = s_spike_valid && s_spike_ready;
  assign pop           = (state == SCAN_IDLE) && enable && !fifo_empty;
  assign advance       = (state == SCAN) && enable && (!m_syn_valid || m_syn_ready);
  assign g_last        = (g == LAST_G);
  // Reads are issued on the pop edge straight from the FIFO head so group 0
  // data is ready the first cycle the FSM sits in SCAN.
  assign rd_en         = pop || (advance && !g_last);
  assign rd_addr       = pop ? addr_of(fifo_axon, 0) : addr_of(axon_q, int'(g) + 1);
  assign cfg_addr      = addr_of(cfg_axon, int'(cfg_neuron) / NUM_LANES);
  assign cfg_lane      = int'(cfg_neuron) % NUM_LANES;
  assign busy          = (fifo_count != '0) || (state == SCAN) || m_syn_valid;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_bank
    logic [WEIGHT_WIDTH-1:0] mem [BANK_DEPTH];
    logic [WEIGHT_WIDTH-1:0] q;

    // NOTE: both statements are non-blocking, so a same-address write and read return the old word.
    always_ff @(posedge clk) begin
      if (cfg_we && cfg_lane == i) mem[cfg_addr] <= cfg_weight;
      if (rd_en)                   q <= mem[rd_addr];
    end

    assign rd_data[lane_lsb(i, WEIGHT_WIDTH) +: WEIGHT_WIDTH] = q;
    assign rd_mask[i] = |q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN_IDLE;
      axon_q         <= '0;
      g              <= '0;
      m_syn_valid    <= 1'b0;
      m_syn_group_id <= '0;
      m_syn_weights  <= '0;
      m_syn_mask     <= '0;
      m_syn_last     <= 1'b0;
      stat_groups    <= '0;
    end else begin
      if (m_syn_valid && m_syn_ready) begin
        m_syn_valid <= 1'b0;
        stat_groups <= stat_groups + 32'd1;
      end
      case (state)
        SCAN_IDLE: begin
          if (pop) begin
            axon_q <= fifo_axon;
            g      <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (advance) begin
            // All-zero groups are dropped, but the final group always closes the spike.
            if (rd_mask != '0 || g_last) begin
              m_syn_valid    <= 1'b1;
              m_syn_group_id <= g;
              m_syn_weights  <= rd_data;
              m_syn_mask     <= rd_mask;
              m_syn_last     <= g_last;
            end
            if (g_last) state <= SCAN_IDLE;
            else        g     <= g + 1'b1;
          end
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

endmodule

// File: doc/synapse_array_mc.md
Name: synapse_array_mc

Overview:
- Next-generation synapse fan-out stage between the spike router and the neuron array.
- Buffers incoming axon spikes in a FIFO and scans each axon's weight row NUM_LANES neurons per cycle from lane-banked weight RAM.
- Emits one neuron-group event per cycle under valid/ready backpressure, with a per-lane nonzero mask and an end-of-spike marker.
- Adds over the previous array: signed weights, multi-lane delivery, input buffering, zero-group skipping, output backpressure and per-lane configuration writes.

Parameters:
NUM_AXONS, 256, input axon count (power of two)
NUM_NEURONS, 256, output neuron count (power of two, multiple of NUM_LANES)
WEIGHT_WIDTH, 8, signed two's-complement weight width
NUM_LANES, 4, neurons delivered per group (power of two)
FIFO_DEPTH, 16, input spike FIFO entries (power of two, ≥2)
AXON_ID_WIDTH, $clog2(NUM_AXONS), derived
NEURON_ID_WIDTH, $clog2(NUM_NEURONS), derived
GROUP_ID_WIDTH, NEURON_ID_WIDTH-$clog2(NUM_LANES), derived (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  scan enable; low freezes scanning
s_spike_valid  in  1  input spike valid
s_spike_ready  out  1  high when the FIFO is not full
s_spike_axon_id  in  AXON_ID_WIDTH  spiking axon
m_syn_valid  out  1  group event valid
m_syn_ready  in  1  downstream accepts group
m_syn_group_id  out  GROUP_ID_WIDTH  first neuron of group = group_id*NUM_LANES
m_syn_weights  out  NUM_LANES*WEIGHT_WIDTH  lane i at bits [i*W +: W], signed
m_syn_mask  out  NUM_LANES  bit i set when lane i weight is nonzero
m_syn_last  out  1  final group of the current spike
cfg_we  in  1  weight write strobe
cfg_axon  in  AXON_ID_WIDTH  write row
cfg_neuron  in  NEURON_ID_WIDTH  write column
cfg_weight  in  WEIGHT_WIDTH  signed weight
busy  out  1  high when the FIFO is non-empty, a scan is active or m_syn_valid is high
stat_groups  out  32  count of accepted m_syn handshakes, wrapping

Behaviour:
- Reset values: all outputs 0 except s_spike_ready=1. Reset flushes the FIFO and aborts any scan, including mid-spike. Weight RAM is not reset; it is zero-initialised at configuration only.
- FIFO: push on s_spike_valid&&s_spike_ready. Pop only in SCAN_IDLE with enable=1. A push and pop in the same cycle are legal when the FIFO is full. s_spike_ready is registered and deasserts exactly when count==FIFO_DEPTH.
- Weight RAM: NUM_LANES banks, each NUM_AXONS*(NUM_NEURONS/NUM_LANES) deep, address = axon*GROUPS+group.
  - cfg write targets bank cfg_neuron%NUM_LANES only.
  - Synchronous read, latency 1, read-first: a same-address write/read returns old data.
  - Bank output holds when read enable is low.
- FSM states:
  - SCAN_IDLE: on pop, latch axon, group counter g=0, issue read of g=0, go to SCAN.
  - SCAN: each cycle where advance=enable&&(!m_syn_valid||m_syn_ready), load the output register from read data for group g. If g is the last group, go to SCAN_IDLE; otherwise issue read g+1 and increment g. When advance=0, hold g, hold the read address and keep read enable low.
- Zero skipping: a group with mask==0 is not presented and consumes one scan cycle. Exception: the last group (g=GROUPS-1) is always presented with m_syn_last=1, even when its mask is 0.
- Output register: m_syn_valid is held with stable data until m_syn_ready. The output register is never overwritten while m_syn_valid&&!m_syn_ready.
- Latency: a spike accepted at cycle T with an empty pipeline pops at T+1, reads at T+2, and shows group 0 at T+3 if it is nonzero.
- Throughput: 1 group/cycle with m_syn_ready=1. A spike costs GROUPS cycles. Back-to-back spikes need one extra SCAN_IDLE cycle.
- enable=0: no pop and no advance; outputs hold; FIFO push and cfg writes continue.
- stat_groups increments on each m_syn_valid&&m_syn_ready and wraps at 2^32.

Decomposition:
- Package snn_syn_pkg holds:
  - derived width functions (group count, GROUP_ID_WIDTH);
  - state encodings SCAN_IDLE/SCAN;
  - lane-slice helper.
- One sub-module, syn_spike_fifo: a synchronous FIFO with registered full/empty and a count output.
- Banks are inferred inline with a generate loop.

Test Plan:
- Config: axon 5 weights n0=+3, n6=-2, all others 0; NUM_LANES=4, NUM_NEURONS=16. Spike axon 5 → exactly three events:
  - g0 mask 0001 w0=3;
  - g1 mask 0100 lane2=-2 (0xFE);
  - g3 mask 0000, last=1.
- Hold m_syn_ready=0 for 5 cycles during the axon-5 scan → the g0 event stays stable; no event lost or duplicated; stat_groups ends at 3.
- Push 17 spikes with enable=0, FIFO_DEPTH=16 → s_spike_ready drops after the 16th push. Raise enable → 16 scans complete in order, each ending in last=1.
- In the same cycle, write axon 2/n1=+7 and read group 0 of axon 2 → the current scan sees the old value 0; the next spike on axon 2 sees 7.
- Assert rst mid-scan of axon 9 with 3 spikes queued → the next cycle has m_syn_valid=0, busy=0 and s_spike_ready=1. A subsequent spike yields a correct full scan with weights retained.
- Random valid/ready traffic on 1000 spikes checked against a reference model → event sequence matches; last count equals spike count.
